rs_issue_scheduler: RTL

Issue scheduler for one shared arithmetic functional unit (FU) in the Tomasulo core. It arbitrates among the `N` arithmetic reservation-station entries whose operands are ready and dispatches one at a time to the FU. It sequences the multi-cycle execution, then holds the result on the Common Data Bus (CDB) request interface until the CDB arbiter accepts it. Finally it frees the owning entry. It sits between the RS array and the CDB arbiter.

---
 rtl/rs_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/rs_issue_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station cluster: FU opcodes,
// the issue-scheduler state encoding and the reserved "no producer" tag.
package rs_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    localparam int TAG_NONE = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        BCAST = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr+1 with
// wrap-around and returns the one-hot grant plus the winner index.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] win
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // NOTE: every output gets a default first so this block can never infer a latch.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDX_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = idx;
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Issue scheduler for one shared multi-cycle arithmetic FU: round-robin issue
// from ready RS entries, LAT-cycle execution, then a held CDB request.
module rs_issue_scheduler
    import rs_pkg::*;
#(
    parameter int N        = 4,
    parameter int TAG_W    = 4,
    parameter int TAG_BASE = 1,
    parameter int LAT      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      rdy,
    input  logic [3*N-1:0]    op_in,
    input  logic [32*N-1:0]   vj_in,
    input  logic [32*N-1:0]   vk_in,
    output logic [N-1:0]      grant,
    output logic [N-1:0]      done,
    output logic              cdb_req,
    input  logic              cdb_gnt,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [31:0]       cdb_data,
    output logic              busy
);

    localparam int IDX_W = $clog2(N);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] win;
    logic [3:0]       cnt;
    logic [2:0]       op_q;
    logic [31:0]      vj_q;
    logic [31:0]      vk_q;
    logic [31:0]      result;
    logic [N-1:0]     arb_gnt;

    rr_arbiter #(.N(N)) u_arb (
        .req (rdy),
        .ptr (ptr),
        .gnt (arb_gnt),
        .win (win)
    );

    assign grant   = (state == IDLE) ? arb_gnt : '0;
    assign cdb_req = (state == BCAST);
    assign busy    = (state != IDLE);

    // The result is only accepted while a request is actually up.
    always_comb begin
        done = '0;
        if (state == BCAST && cdb_gnt)
            done[owner] = 1'b1;
    end

    always_comb begin
        result = '0;
        case (op_q)
            OP_ADD:  result = vj_q + vk_q;
            OP_SUB:  result = vj_q - vk_q;
            OP_AND:  result = vj_q & vk_q;
            OP_OR:   result = vj_q | vk_q;
            OP_XOR:  result = vj_q ^ vk_q;
            OP_SLL:  result = vj_q << vk_q[4:0];
            OP_SRL:  result = vj_q >> vk_q[4:0];
            OP_SLT:  result = {31'b0, $signed(vj_q) < $signed(vk_q)};
            default: result = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= IDX_W'(N - 1);
            owner    <= '0;
            cnt      <= '0;
            op_q     <= OP_ADD;
            vj_q     <= '0;
            vk_q     <= '0;
            cdb_tag  <= TAG_W'(TAG_NONE);
            cdb_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|rdy) begin
                        op_q  <= op_in[3*win +: 3];
                        vj_q  <= vj_in[32*win +: 32];
                        vk_q  <= vk_in[32*win +: 32];
                        owner <= win;
                        cnt   <= 4'(LAT);
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd1) begin
                        cdb_data <= result;
                        cdb_tag  <= TAG_W'(TAG_BASE + int'(owner));
                        cnt      <= '0;
                        state    <= BCAST;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                BCAST: begin
                    // Pointer advances only on acceptance, so a stalled winner keeps its turn.
                    if (cdb_gnt) begin
                        ptr   <= owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
